// File: rtl/serin_sequencer_if.sv
// ---------------------------------------------------------------------------
// serin_sequencer_if
//   Groups the receive-sequencer signals shared between the bit timer /
//   register block (master side) and serin_sequencer (slave side).
//   master : drives enable, sid, bitTick, serinAck, errClr;
//            observes timerRst, busy, serinData, serinRdy, rdyPending,
//            frameErr, overrun
//   slave  : the reverse directions
// ---------------------------------------------------------------------------
interface serin_sequencer_if #(
   parameter int unsigned DATA_BITS = 8
);
   logic                 enable;
   logic                 sid;
   logic                 bitTick;
   logic                 serinAck;
   logic                 errClr;
   logic                 timerRst;
   logic                 busy;
   logic [DATA_BITS-1:0] serinData;
   logic                 serinRdy;
   logic                 rdyPending;
   logic                 frameErr;
   logic                 overrun;

   modport master (
      output enable, sid, bitTick, serinAck, errClr,
      input  timerRst, busy, serinData, serinRdy, rdyPending, frameErr, overrun
   );

   modport slave (
      input  enable, sid, bitTick, serinAck, errClr,
      output timerRst, busy, serinData, serinRdy, rdyPending, frameErr, overrun
   );
endinterface

// File: rtl/serin_sequencer.sv
// ---------------------------------------------------------------------------
// serin_sequencer
//   Receive-side sequencer for the POKEY SERIN path. Synchronises sid,
//   detects the start edge, shifts DATA_BITS bits LSB first on bitTick,
//   checks the stop bit, loads serinData and pulses serinRdy. Keeps the
//   rdyPending flag and the sticky frameErr / overrun status bits.
// Ports
//   clk     : system clock, rising edge
//   nReset  : asynchronous active-low reset
//   bus     : serin_sequencer_if.slave
//             in  enable, sid, bitTick, serinAck, errClr
//             out timerRst, busy, serinData, serinRdy, rdyPending,
//                 frameErr, overrun
// ---------------------------------------------------------------------------
module serin_sequencer #(
   parameter int unsigned DATA_BITS   = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              nReset,
   serin_sequencer_if.slave  bus
);

   localparam int unsigned CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sidS;
   logic                   sidPrev_q;
   state_t                 state_q;
   logic [CNT_W-1:0]       bitCnt_q;
   logic [DATA_BITS-1:0]   shreg_q;
   logic [DATA_BITS-1:0]   serinData_q;
   logic                   timerRst_q;
   logic                   serinRdy_q;
   logic                   rdyPending_q, rdyPending_d;
   logic                   frameErr_q,   frameErr_d;
   logic                   overrun_q,    overrun_d;
   logic                   startEdge;
   logic                   frameDone;

   // Input synchroniser, resets to mark (1).
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], bus.sid};
      end
   end

   assign sidS = sync_q[SYNC_STAGES-1];

   // sidPrev_q tracks sidS in every state, so after a disabled period or a
   // low stop bit a line that is already low never looks like a fresh edge.
   assign startEdge = bus.enable && (state_q == IDLE) && sidPrev_q && !sidS;
   assign frameDone = bus.enable && (state_q == STOP) && bus.bitTick;

   // Flag next-state: set beats clear when they coincide.
   always_comb begin
      rdyPending_d = rdyPending_q;
      if (bus.serinAck) rdyPending_d = 1'b0;
      if (frameDone)    rdyPending_d = 1'b1;

      frameErr_d = frameErr_q;
      if (bus.errClr)            frameErr_d = 1'b0;
      if (frameDone && !sidS)    frameErr_d = 1'b1;

      overrun_d = overrun_q;
      if (bus.errClr) overrun_d = 1'b0;
      if (frameDone && rdyPending_q && !bus.serinAck) overrun_d = 1'b1;
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         sidPrev_q    <= 1'b1;
         state_q      <= IDLE;
         bitCnt_q     <= '0;
         shreg_q      <= '0;
         serinData_q  <= '0;
         timerRst_q   <= 1'b0;
         serinRdy_q   <= 1'b0;
         rdyPending_q <= 1'b0;
         frameErr_q   <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         sidPrev_q    <= sidS;
         timerRst_q   <= 1'b0;
         serinRdy_q   <= 1'b0;
         rdyPending_q <= rdyPending_d;
         frameErr_q   <= frameErr_d;
         overrun_q    <= overrun_d;

         if (!bus.enable) begin
            state_q  <= IDLE;
            bitCnt_q <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (startEdge) begin
                     state_q    <= START;
                     timerRst_q <= 1'b1;
                  end
               end
               START: begin
                  if (bus.bitTick) begin
                     if (!sidS) begin
                        state_q  <= DATA;
                        bitCnt_q <= '0;
                     end else begin
                        // Start bit not held to centre: treat as a glitch.
                        state_q <= IDLE;
                     end
                  end
               end
               DATA: begin
                  if (bus.bitTick) begin
                     shreg_q  <= {sidS, shreg_q[DATA_BITS-1:1]};
                     bitCnt_q <= bitCnt_q + CNT_W'(1);
                     if (bitCnt_q == LAST_BIT) begin
                        state_q <= STOP;
                     end
                  end
               end
               STOP: begin
                  if (frameDone) begin
                     serinData_q <= shreg_q;
                     serinRdy_q  <= 1'b1;
                     state_q     <= IDLE;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign bus.timerRst   = timerRst_q;
   assign bus.busy       = (state_q != IDLE);
   assign bus.serinData  = serinData_q;
   assign bus.serinRdy   = serinRdy_q;
   assign bus.rdyPending = rdyPending_q;
   assign bus.frameErr   = frameErr_q;
   assign bus.overrun    = overrun_q;

endmodule
